// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: AXI4-Lite line prefetcher feeding a 16-bit parcel queue,
// with RVC/32-bit instruction assembly, redirect and sticky exceptions.
`ifndef ALEN
`define ALEN 32
`endif
module ifetch_prefetch #(
  parameter int LINE_BITS       = 64,
  parameter int QUEUE_PARCELS   = 8,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = `ALEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic [ADDR_W-1:0]    i_pc,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [31:0]          o_out_instr,
  output logic [ADDR_W-1:0]    o_out_addr,
  output logic [ADDR_W-1:0]    o_out_next_addr,
  output logic                 o_out_exception,
  output logic [1:0]           o_out_cause,
  output logic                 o_arvalid,
  input  logic                 i_arready,
  output logic [ADDR_W-1:0]    o_araddr,
  output logic [2:0]           o_arprot,
  input  logic                 i_rvalid,
  output logic                 o_rready,
  input  logic [LINE_BITS-1:0] i_rdata,
  input  logic [1:0]           i_rresp,
  output logic                 o_awvalid,
  output logic                 o_wvalid,
  output logic                 o_bready
);
  localparam int PPL = LINE_BITS / 16;
  localparam int OFB = $clog2(LINE_BITS / 8);
  localparam int SKW = OFB - 1;
  localparam int QA  = $clog2(QUEUE_PARCELS);
  localparam int CW  = QA + 1;
  typedef enum logic {S_RUN, S_EXC} state_t;
  state_t r_state, w_state_nx;
  logic [16:0] r_q [QUEUE_PARCELS];
  logic r_init, r_stop;
  logic [CW-1:0] r_cnt, w_enq_n, w_deq_n;
  logic [QA-1:0] r_rd, r_wr;
  logic [2:0] r_infl, r_disc, w_infl_nx, w_pend;
  logic [SKW-1:0] r_skip;
  logic [ADDR_W-1:0] r_faddr, r_qaddr, r_eaddr;
  logic [1:0] r_cause, w_q_cause;
  logic [16:0] w_head, w_sec;
  logic [15:0] w_resv;
  logic w_flush, w_ar_hs, w_r_hs, w_drop, w_enq, w_rerr, w_deq;
  logic w_comp, w_ill, w_two, w_serr, w_q_valid, w_q_exc, w_exc, w_ok;
  // The first cycle after reset release behaves as a redirect to i_pc.
  assign w_flush   = i_flush | r_init;
  assign w_ar_hs   = o_arvalid & i_arready;
  assign w_r_hs    = i_rvalid & o_rready;
  assign w_drop    = r_disc != 3'd0;
  assign w_rerr    = i_rresp != 2'b00;
  assign w_enq     = w_r_hs & !w_drop & !w_flush;
  assign w_enq_n   = !w_enq ? CW'(0) : w_rerr ? CW'(1) : CW'(PPL) - CW'(r_skip);
  assign w_infl_nx = r_infl + {2'b0, w_ar_hs} - {2'b0, w_r_hs};
  assign w_head    = r_q[r_rd];
  assign w_sec     = r_q[r_rd + QA'(1)];
  assign w_comp    = w_head[1:0] != 2'b11;
  assign w_ill     = w_head[4:0] == 5'h1f;
  assign w_two     = r_cnt >= CW'(2);
  assign w_serr    = !w_comp & !w_ill & w_two & w_sec[16];
  assign w_q_valid = (r_cnt != CW'(0)) & (w_head[16] | w_comp | w_ill | w_two);
  assign w_q_exc   = w_head[16] | w_ill | w_serr;
  assign w_q_cause = (w_head[16] | w_serr) ? 2'd1 : 2'd2;
  assign w_exc     = r_state == S_EXC;
  assign w_ok      = !w_exc & w_q_valid & !w_q_exc;
  assign w_deq     = !w_flush & w_ok & i_out_ready;
  assign w_deq_n   = !w_deq ? CW'(0) : w_comp ? CW'(1) : CW'(2);
  // Each issued, non-discarded read reserves a full line of queue space.
  assign w_pend    = r_infl - r_disc;
  assign w_resv    = 16'(r_cnt) + 16'(PPL) * (16'(w_pend) + 16'd1);
  assign o_arvalid = !r_init & !w_exc & !r_stop & (r_infl < 3'(MAX_OUTSTANDING)) &
                     (w_resv <= 16'(QUEUE_PARCELS));
  assign o_araddr  = r_faddr;
  assign o_arprot  = 3'b000;
  assign o_rready  = r_infl != 3'd0;
  assign o_awvalid = 1'b0;
  assign o_wvalid  = 1'b0;
  assign o_bready  = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_RUN;
    else r_state <= w_state_nx;
  always_comb
    w_state_nx = w_flush ? (i_pc[0] ? S_EXC : S_RUN) :
                 (!w_exc & w_q_valid & w_q_exc) ? S_EXC : r_state;
  always_comb begin
    o_out_valid     = w_exc | w_q_valid;
    o_out_exception = w_exc | (w_q_valid & w_q_exc);
    o_out_cause     = w_exc ? r_cause : (w_q_valid & w_q_exc) ? w_q_cause : 2'd0;
    o_out_addr      = w_exc ? r_eaddr : r_qaddr;
    o_out_instr     = !w_ok ? 32'h0 : w_comp ? {16'h0, w_head[15:0]} : {w_sec[15:0], w_head[15:0]};
    o_out_next_addr = o_out_addr + ADDR_W'(w_ok & w_comp ? 2 : 4);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_init  <= 1'b1;
      r_stop  <= 1'b0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_infl  <= '0;
      r_disc  <= '0;
      r_skip  <= '0;
      r_faddr <= '0;
      r_qaddr <= '0;
      r_eaddr <= '0;
      r_cause <= '0;
    end else begin
      r_init <= 1'b0;
      r_infl <= w_infl_nx;
      if (w_flush) begin
        r_disc  <= w_infl_nx;
        r_cnt   <= '0;
        r_rd    <= '0;
        r_wr    <= '0;
        r_stop  <= 1'b0;
        r_faddr <= {i_pc[ADDR_W-1:OFB], {OFB{1'b0}}};
        r_skip  <= i_pc[OFB-1:1];
        r_qaddr <= i_pc;
        r_eaddr <= i_pc;
        r_cause <= 2'd0;
      end else begin
        if (w_r_hs & w_drop) r_disc <= r_disc - 3'd1;
        if (w_ar_hs) r_faddr <= r_faddr + ADDR_W'(LINE_BITS / 8);
        if (w_enq) begin
          r_skip <= '0;
          r_stop <= r_stop | w_rerr;
        end
        r_cnt <= r_cnt + w_enq_n - w_deq_n;
        r_wr  <= r_wr + QA'(w_enq_n);
        r_rd  <= r_rd + QA'(w_deq_n);
        if (w_deq) r_qaddr <= r_qaddr + ADDR_W'(w_comp ? 2 : 4);
        if (!w_exc & w_q_valid & w_q_exc) begin
          r_cause <= w_q_cause;
          r_eaddr <= r_qaddr;
        end
      end
    end
  // A bus error becomes a single marker parcel in place of the line's data.
  always_ff @(posedge clk)
    if (w_enq & w_rerr) r_q[r_wr] <= {1'b1, 16'h0};
    else if (w_enq)
      for (int i = 0; i < PPL; i++)
        if (i >= int'(r_skip)) r_q[r_wr + QA'(i - int'(r_skip))] <= {1'b0, i_rdata[16*i +: 16]};
  a_cnt: assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= CW'(QUEUE_PARCELS));
  a_rv:  assert property (@(posedge clk) disable iff (!rst_n) !(i_rvalid && r_infl == 3'd0));
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: directed bench for ifetch_prefetch with a small AXI4-Lite read slave.
module tb_ifetch_prefetch;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, out_ready = 1'b1, arready = 1'b1, rvalid = 1'b0;
  logic [31:0] pc = '0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        out_valid, out_exception, arvalid, rready, awvalid, wvalid, bready;
  logic [31:0] out_instr, out_addr, out_next_addr, araddr;
  logic [1:0]  out_cause;
  logic [2:0]  arprot;
  int n_chk = 0, n_fail = 0, cyc = 0, lat = 1, img = 0, n0 = 0;
  bit seen_ar;
  logic [31:0] err_line = '1;
  logic [31:0] rq_a[$];
  int          rq_t[$];
  logic [31:0] ar_log[$];

  ifetch_prefetch dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_pc(pc),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_instr(out_instr),
    .o_out_addr(out_addr), .o_out_next_addr(out_next_addr),
    .o_out_exception(out_exception), .o_out_cause(out_cause),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arprot(arprot),
    .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp),
    .o_awvalid(awvalid), .o_wvalid(wvalid), .o_bready(bready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] parcel(logic [31:0] a);
    if (img == 1) return {a[11:0], 4'h3};
    if (img == 2) return a == 32'h2000 ? 16'h4501 : a == 32'h2002 ? 16'h0093 :
                         a == 32'h2004 ? 16'h00A0 : 16'h0001;
    if (img == 3 && a == 32'h6000) return 16'hFFFF;
    return a[1] ? a[15:0] : {a[15:4], a[2], 3'b011};
  endfunction

  function automatic logic [63:0] line(logic [31:0] a);
    logic [63:0] l;
    for (int i = 0; i < 4; i++) l[16*i +: 16] = parcel(a + 32'(2*i));
    return l;
  endfunction

  task automatic tick();
    bit ah, rh;
    logic [31:0] aa;
    ah = arvalid && arready;
    aa = araddr;
    rh = rvalid && rready;
    @(posedge clk);
    #1;
    cyc++;
    if (rh) begin
      void'(rq_a.pop_front());
      void'(rq_t.pop_front());
    end
    if (ah) begin
      rq_a.push_back(aa);
      rq_t.push_back(cyc + lat - 1);
      ar_log.push_back(aa);
    end
    rvalid = rq_a.size() > 0 && rq_t[0] <= cyc;
    rdata  = rvalid ? line(rq_a[0]) : '0;
    rresp  = (rvalid && rq_a[0] == err_line) ? 2'b10 : 2'b00;
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_flush(logic [31:0] p);
    flush = 1'b1;
    pc = p;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_valid(string tag, int budget);
    int k = 0;
    while (!out_valid && k < budget) begin
      tick();
      k++;
    end
    chk({tag, " valid timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic expect_out(string tag, logic [31:0] ins, logic [31:0] a, logic [31:0] na);
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " instr"}, 64'(out_instr), 64'(ins));
    chk({tag, " addr"}, 64'(out_addr), 64'(a));
    chk({tag, " next"}, 64'(out_next_addr), 64'(na));
    chk({tag, " exc"}, 64'(out_exception), 64'd0);
    tick();
  endtask

  task automatic expect_exc(string tag, logic [1:0] c, logic [31:0] a);
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " exc"}, 64'(out_exception), 64'd1);
    chk({tag, " cause"}, 64'(out_cause), 64'(c));
    chk({tag, " addr"}, 64'(out_addr), 64'(a));
    chk({tag, " instr"}, 64'(out_instr), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pc = 32'h1000;
    repeat (3) tick();
    chk("rst valid", 64'(out_valid), 64'd0);
    chk("rst arvalid", 64'(arvalid), 64'd0);
    chk("rst exc", 64'(out_exception), 64'd0);
    chk("rst instr", 64'(out_instr), 64'd0);
    chk("rst cause", 64'(out_cause), 64'd0);
    chk("rst rready", 64'(rready), 64'd0);
    chk("rst tieoffs", {58'd0, arprot, awvalid, wvalid, bready}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("init cycle arvalid", 64'(arvalid), 64'd0);
    tick();
    chk("first ar valid", 64'(arvalid), 64'd1);
    chk("first ar addr", 64'(araddr), 64'h1000);
    // Straight-line 32-bit stream from 0x1000
    wait_valid("t1", 20);
    expect_out("t1 i0", 32'h10021003, 32'h1000, 32'h1004);
    expect_out("t1 i1", 32'h1006100B, 32'h1004, 32'h1008);
    expect_out("t1 i2", 32'h100A1003, 32'h1008, 32'h100C);
    expect_out("t1 i3", 32'h100E100B, 32'h100C, 32'h1010);
    chk("t1 ar0", 64'(ar_log[0]), 64'h1000);
    chk("t1 ar1", 64'(ar_log[1]), 64'h1008);
    // 32-bit instruction straddling a line boundary
    img = 1;
    do_flush(32'h1006);
    chk("t2 cleared", 64'(out_valid), 64'd0);
    wait_valid("t2", 20);
    expect_out("t2 i0", 32'h00830063, 32'h1006, 32'h100A);
    expect_out("t2 i1", 32'h00C300A3, 32'h100A, 32'h100E);
    // Mixed compressed / 32-bit
    img = 2;
    do_flush(32'h2000);
    wait_valid("t3", 20);
    expect_out("t3 c0", 32'h00004501, 32'h2000, 32'h2002);
    expect_out("t3 w1", 32'h00A00093, 32'h2002, 32'h2006);
    expect_out("t3 c2", 32'h00000001, 32'h2006, 32'h2008);
    // Misaligned pc: sticky cause 0, no reads
    do_flush(32'h1001);
    expect_exc("t5 mis", 2'd0, 32'h1001);
    chk("t5 arvalid", 64'(arvalid), 64'd0);
    seen_ar = 1'b0;
    repeat (4) begin
      tick();
      seen_ar |= arvalid;
    end
    expect_exc("t5 hold", 2'd0, 32'h1001);
    chk("t5 no ar", 64'(seen_ar), 64'd0);
    // Two reads in flight, redirected before either returns
    lat = 4;
    img = 0;
    do_flush(32'h1000);
    n0 = ar_log.size();
    tick();
    tick();
    chk("t4 two ar", 64'(ar_log.size() - n0), 64'd2);
    chk("t4 no r yet", 64'(rvalid), 64'd0);
    chk("t4 ar a", 64'(ar_log[n0]), 64'h1000);
    chk("t4 ar b", 64'(ar_log[n0+1]), 64'h1008);
    do_flush(32'h3000);
    chk("t4 cleared", 64'(out_valid), 64'd0);
    wait_valid("t4", 40);
    expect_out("t4 i0", 32'h30023003, 32'h3000, 32'h3004);
    expect_out("t4 i1", 32'h3006300B, 32'h3004, 32'h3008);
    chk("t4 new ar", 64'(ar_log[n0+2]), 64'h3000);
    // Bus error on the second line
    lat = 1;
    err_line = 32'h4008;
    do_flush(32'h4000);
    wait_valid("t6", 30);
    expect_out("t6 i0", 32'h40024003, 32'h4000, 32'h4004);
    wait_valid("t6b", 10);
    expect_out("t6 i1", 32'h4006400B, 32'h4004, 32'h4008);
    wait_valid("t6c", 10);
    expect_exc("t6 berr", 2'd1, 32'h4008);
    seen_ar = 1'b0;
    repeat (4) begin
      tick();
      seen_ar |= arvalid;
    end
    expect_exc("t6 sticky", 2'd1, 32'h4008);
    chk("t6 no ar", 64'(seen_ar), 64'd0);
    // Illegal-length parcel at head
    err_line = '1;
    img = 3;
    do_flush(32'h6000);
    wait_valid("t7", 30);
    expect_exc("t7 ill", 2'd2, 32'h6000);
    tick();
    expect_exc("t7 sticky", 2'd2, 32'h6000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
